shift_sequencer: RTL and testbench

Multi-cycle shift/rotate unit for the multicycle datapath. It accepts one operand, a shift amount and an operation over a valid/ready handshake. It reaches the result by stepping an internal register 2 positions per cycle, or 1 for the final odd step, then holds the result until the consumer takes it. It replaces a barrel shifter in the ALU shift path (SLL/SRL/ROR/ROL by shamt), trading latency for area.

---
 rtl/shift_seq_pkg.sv | 17 +
 rtl/shift_step.sv | 24 ++
 rtl/shift_sequencer.sv | 115 +++++++++++
 tb/tb_shift_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types for the multi-cycle shift/rotate sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROR = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One shift/rotate step of 1 or 2 positions on the data feedback path.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned SIZE = 12
) (
  input  logic [SIZE-1:0] d,
  input  op_e             op,
  input  logic            two,
  output logic [SIZE-1:0] q
);

  always_comb begin
    q = d;
    unique case (op)
      OP_SLL: q = two ? {d[SIZE-3:0], 2'b00} : {d[SIZE-2:0], 1'b0};
      OP_SRL: q = two ? {2'b00, d[SIZE-1:2]} : {1'b0, d[SIZE-1:1]};
      OP_ROR: q = two ? {d[1:0], d[SIZE-1:2]} : {d[0], d[SIZE-1:1]};
      OP_ROL: q = two ? {d[SIZE-3:0], d[SIZE-1:SIZE-2]} : {d[SIZE-2:0], d[SIZE-1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: steps data 2 bits per cycle (1 for an odd tail)
// behind a valid/ready handshake on both sides.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned SIZE    = 12,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SIZE-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIZE-1:0]    out_data,
  output logic               busy
);

  localparam int unsigned REM_W = $clog2(SIZE + 1);
  localparam int unsigned AW    = (SHAMT_W > REM_W) ? SHAMT_W : REM_W;

  state_e            state_q, state_d;
  logic [SIZE-1:0]   data_q;
  logic [SIZE-1:0]   step_q;
  logic [REM_W-1:0]  rem_q;
  logic [REM_W-1:0]  rem_next;
  logic [REM_W-1:0]  amt;
  logic [AW-1:0]     n_w;
  logic [AW-1:0]     m_w;
  op_e               op_q;
  op_e               in_op_e;
  logic              two;

  assign in_op_e = op_e'(in_op);

  // Effective amount: rotates wrap once (n < 2*SIZE), logical shifts saturate at SIZE.
  always_comb begin
    n_w = AW'(in_shamt);
    m_w = n_w;
    if (in_op_e == OP_ROR || in_op_e == OP_ROL) begin
      if (n_w >= AW'(SIZE)) m_w = n_w - AW'(SIZE);
    end else if (n_w > AW'(SIZE)) begin
      m_w = AW'(SIZE);
    end
  end
  assign amt = REM_W'(m_w);

  assign two      = (rem_q >= REM_W'(2));
  assign rem_next = rem_q - (two ? REM_W'(2) : REM_W'(1));

  shift_step #(.SIZE(SIZE)) u_step (
    .d   (data_q),
    .op  (op_q),
    .two (two),
    .q   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and state-decoded handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (amt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (rem_next == '0) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      rem_q  <= '0;
      op_q   <= OP_SLL;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            op_q   <= in_op_e;
            rem_q  <= amt;
          end
        end
        SHIFT: begin
          data_q <= step_q;
          rem_q  <= rem_next;
        end
        default: ;
      endcase
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: driver pushes expected results, monitor pops on handshake.
module tb_shift_sequencer;

  localparam int unsigned SIZE    = 12;
  localparam int unsigned SHAMT_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [SIZE-1:0]    in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [SIZE-1:0]    out_data;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  logic [SIZE-1:0] exp_q[$];

  shift_sequencer #(.SIZE(SIZE), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each completed output handshake against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got 0x%0h with empty scoreboard", out_data);
      end else begin
        logic [SIZE-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL out_data: got 0x%0h expected 0x%0h", out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int lat);
    int cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'(lat));
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({name, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string name, input logic [SIZE-1:0] d, input logic [SHAMT_W-1:0] n,
                       input logic [1:0] op, input logic [SIZE-1:0] exp, input int lat);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = n;
    in_op    = op;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    in_data  = SIZE'($urandom);
    in_shamt = SHAMT_W'($urandom);
    in_op    = 2'($urandom);
    wait_valid(name, lat);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    handshake(name);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);

    do_op("sll_5",   12'h001, 4'd5,  2'b00, 12'h020, 3);
    do_op("ror_13",  12'h801, 4'd13, 2'b10, 12'hC00, 1);
    do_op("rol_4",   12'hABC, 4'd4,  2'b11, 12'hBCA, 2);
    do_op("srl_15",  12'hFFF, 4'd15, 2'b01, 12'h000, 6);
    do_op("sll_0",   12'h5A5, 4'd0,  2'b00, 12'h5A5, 0);
    do_op("ror_12",  12'hABC, 4'd12, 2'b10, 12'hABC, 0);
    do_op("rol_15",  12'h801, 4'd15, 2'b11, 12'h00C, 2);
    do_op("sll_12",  12'hFFF, 4'd12, 2'b00, 12'h000, 6);
    do_op("srl_11",  12'h800, 4'd11, 2'b01, 12'h001, 6);
    do_op("ror_7",   12'h00F, 4'd7,  2'b10, 12'h1E0, 4);

    // Backpressure with a second request held on in_valid the whole time.
    in_valid = 1'b1;
    in_data  = 12'hF0F;
    in_shamt = 4'd3;
    in_op    = 2'b01;
    exp_q.push_back(12'h1E1);
    tick();
    in_data  = 12'h00F;
    in_shamt = 4'd1;
    in_op    = 2'b00;
    wait_valid("bp_a", 2);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_data",  32'(out_data),  32'h1E1);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_ready", 32'(in_ready),  32'd1);
    chk("bp_idle_busy",  32'(busy),      32'd0);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(12'h01E);
    tick();
    in_valid = 1'b0;
    wait_valid("bp_b", 1);
    handshake("bp_b");

    // Reset during the second SHIFT cycle of SRL 0xF00 by 8; result is discarded.
    in_valid = 1'b1;
    in_data  = 12'hF00;
    in_shamt = 4'd8;
    in_op    = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_out_data",  32'(out_data),  32'd0);
    do_op("rol_after_rst", 12'h123, 4'd2, 2'b11, 12'h48C, 1);

    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
